// File: rtl/fifo_addr_gen_if.sv
// Address-generator bus: the advance request plus the address, look-ahead
// address, wrap pulse and lap bit it produces.
interface fifo_addr_gen_if #(
   parameter int ADDR_WIDTH = 4
);
   logic                  inc;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic                  wrap;
   logic                  phase;

   // The FIFO controller drives inc and consumes the rest.
   modport master (
      output inc,
      input  addr,
      input  addr_next,
      input  wrap,
      input  phase
   );

   modport slave (
      input  inc,
      output addr,
      output addr_next,
      output wrap,
      output phase
   );
endinterface : fifo_addr_gen_if

// File: rtl/fifo_addr_gen.sv
// Modulo-2**ADDR_WIDTH FIFO address counter with wrap pulse and optional lap bit.
// Define FIFO_ADDR_GEN_PHASE_EN to build the phase register; otherwise phase is tied 0.
module fifo_addr_gen #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   fifo_addr_gen_if.slave gen
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   // NOTE: declaration initialisers give the registers their reset values at
   // power-up as well; the synchronous reset below still governs at run time.
   logic [ADDR_WIDTH-1:0] addr_q = '0;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic                  wrap_q = 1'b0;
   logic                  wrap_d;

   logic [ADDR_WIDTH-1:0] addr_inc;
   logic                  at_last;

   // Natural ADDR_WIDTH-bit overflow provides the modulo wrap.
   assign addr_inc = addr_q + 1'b1;
   assign at_last  = (addr_q == LAST_ADDR);

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      addr_d = addr_q;
      wrap_d = 1'b0;
      if (gen.inc) begin
         addr_d = addr_inc;
         wrap_d = at_last;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         wrap_q <= 1'b0;
      end else begin
         addr_q <= addr_d;
         wrap_q <= wrap_d;
      end
   end

   assign gen.addr      = addr_q;
   assign gen.addr_next = addr_inc;
   assign gen.wrap      = wrap_q;

`ifdef FIFO_ADDR_GEN_PHASE_EN
   // Lap bit: {phase,addr} pairs let a parent tell full from empty.
   logic phase_q = 1'b0;
   logic phase_d;

   always_comb begin
      phase_d = phase_q;
      if (gen.inc && at_last) begin
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign gen.phase = phase_q;
`else
   assign gen.phase = 1'b0;
`endif

endmodule : fifo_addr_gen

// File: tb/tb_fifo_addr_gen.sv
// Self-checking bench for fifo_addr_gen at ADDR_WIDTH 4, 2 and 1 driven in lockstep,
// compared every cycle against a reference counter through a scoreboard queue.
module tb_fifo_addr_gen;

`ifdef FIFO_ADDR_GEN_PHASE_EN
   localparam bit PHASE_EN = 1'b1;
`else
   localparam bit PHASE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic inc = 1'b0;

   always #5 clk = ~clk;

   fifo_addr_gen_if #(.ADDR_WIDTH(4)) if4 ();
   fifo_addr_gen_if #(.ADDR_WIDTH(2)) if2 ();
   fifo_addr_gen_if #(.ADDR_WIDTH(1)) if1 ();

   assign if4.inc = inc;
   assign if2.inc = inc;
   assign if1.inc = inc;

   fifo_addr_gen #(.ADDR_WIDTH(4)) dut4 (.clk(clk), .rst(rst), .gen(if4));
   fifo_addr_gen #(.ADDR_WIDTH(2)) dut2 (.clk(clk), .rst(rst), .gen(if2));
   fifo_addr_gen #(.ADDR_WIDTH(1)) dut1 (.clk(clk), .rst(rst), .gen(if1));

   typedef struct {
      int   a4; logic w4; logic p4;
      int   a2; logic w2; logic p2;
      int   a1; logic w1; logic p1;
   } exp_t;

   exp_t sb_q[$];
   exp_t m;          // reference state

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference counter for one generator of the given depth.
   task automatic ref_adv(input int depth, input logic r, input logic i,
                          input int a_in, input logic p_in,
                          output int a_out, output logic w_out, output logic p_out);
      a_out = a_in; w_out = 1'b0; p_out = p_in;
      if (r) begin
         a_out = 0; p_out = 1'b0;
      end else if (i) begin
         w_out = (a_in == depth - 1);
         if (w_out && PHASE_EN) p_out = ~p_in;
         a_out = (a_in + 1) % depth;
      end
   endtask

   task automatic compare_all(input exp_t e, input string ctx);
      check({ctx, " addr4"},  int'(if4.addr),      e.a4);
      check({ctx, " next4"},  int'(if4.addr_next), (e.a4 + 1) % 16);
      check({ctx, " wrap4"},  int'(if4.wrap),      int'(e.w4));
      check({ctx, " phase4"}, int'(if4.phase),     int'(e.p4));
      check({ctx, " addr2"},  int'(if2.addr),      e.a2);
      check({ctx, " next2"},  int'(if2.addr_next), (e.a2 + 1) % 4);
      check({ctx, " wrap2"},  int'(if2.wrap),      int'(e.w2));
      check({ctx, " phase2"}, int'(if2.phase),     int'(e.p2));
      check({ctx, " addr1"},  int'(if1.addr),      e.a1);
      check({ctx, " next1"},  int'(if1.addr_next), (e.a1 + 1) % 2);
      check({ctx, " wrap1"},  int'(if1.wrap),      int'(e.w1));
      check({ctx, " phase1"}, int'(if1.phase),     int'(e.p1));
   endtask

   // One clock: drive inputs, push the expected result, compare after the edge.
   task automatic step(input logic i, input logic r, input string ctx);
      exp_t e;
      @(negedge clk);
      inc = i;
      rst = r;
      ref_adv(16, r, i, m.a4, m.p4, m.a4, m.w4, m.p4);
      ref_adv(4,  r, i, m.a2, m.p2, m.a2, m.w2, m.p2);
      ref_adv(2,  r, i, m.a1, m.p1, m.a1, m.w1, m.p1);
      sb_q.push_back(m);
      @(posedge clk);
      #1;
      check({ctx, " sb_depth"}, sb_q.size(), 1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         compare_all(e, ctx);
      end
   endtask

   int wrap2_cnt;
   int ph2_cnt;
   logic ph2_prev;

   initial begin
      m = '{default: 0};

      // Power-up values before any clock edge.
      #1;
      compare_all(m, "powerup");

      // Two reset cycles; addr_next reads 1 while in reset.
      step(1'b0, 1'b1, "reset");
      step(1'b0, 1'b1, "reset");

      // Sixteen back-to-back increments: 1..15 then 0, one wrap.
      for (int k = 0; k < 16; k++) step(1'b1, 1'b0, "run16");
      step(1'b0, 1'b0, "run16_after");

      // Alternating inc.
      for (int k = 0; k < 10; k++) step(k % 2 == 0, 1'b0, "alt");

      // Reach 9, then reset with inc high, then one inc.
      while (m.a4 != 9) step(1'b1, 1'b0, "to9");
      step(1'b1, 1'b1, "rst_over_inc");
      step(1'b1, 1'b0, "first_inc");

      // Park at 15 and hold.
      while (m.a4 != 15) step(1'b1, 1'b0, "to15");
      for (int k = 0; k < 5; k++) step(1'b0, 1'b0, "hold15");

      // Width-2 generator: 12 increments from reset, count wraps and phase toggles.
      step(1'b0, 1'b1, "rst2");
      wrap2_cnt = 0;
      ph2_cnt   = 0;
      ph2_prev  = if2.phase;
      for (int k = 0; k < 12; k++) begin
         step(1'b1, 1'b0, "w2run");
         if (if2.wrap === 1'b1) wrap2_cnt++;
         if (if2.phase !== ph2_prev) ph2_cnt++;
         ph2_prev = if2.phase;
      end
      check("w2_wrap_count",  wrap2_cnt, 3);
      check("w2_phase_flips", ph2_cnt, PHASE_EN ? 3 : 0);

      // Randomised inc stream with occasional resets.
      for (int k = 0; k < 300; k++)
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0), "rand");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_fifo_addr_gen

// File: doc/fifo_addr_gen.md
FIFO_ADDR_GEN -- requirements
Module: fifo_addr_gen

Interface
REQ-001 Parameter: ADDR_WIDTH, default 4, address width in bits; the address space DEPTH is 2**ADDR_WIDTH; legal range 1..16.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: inc  input  1  advance request; when high at a clock edge, the address advances by one.
REQ-005 Port: addr  output  ADDR_WIDTH  current address, driven directly from a register.
REQ-006 Port: addr_next  output  ADDR_WIDTH  combinational value (addr+1) mod DEPTH, independent of inc.
REQ-007 Port: wrap  output  1  registered one-cycle pulse, high in the cycle after addr changed from DEPTH-1 to 0.
REQ-008 Port: phase  output  1  registered lap bit, toggles on every wrap; see Configuration.

Function
REQ-009 On a rising clk edge with rst low and inc high, addr SHALL become (addr+1) mod DEPTH.
REQ-010 On a rising clk edge with rst low and inc low, addr, phase and the stored state SHALL hold.
REQ-011 Arithmetic SHALL be ADDR_WIDTH-bit modulo: DEPTH-1 plus 1 wraps to 0, with no extra states and no saturation.
REQ-012 Update latency SHALL be one clock: addr reflects an inc sampled at edge N immediately after edge N.
REQ-013 wrap SHALL be 1 for exactly one cycle after an edge where inc was high and addr was DEPTH-1; otherwise 0.
REQ-014 Consecutive inc cycles SHALL advance addr on every edge, one step per edge, with no bubbles.
REQ-015 addr_next SHALL always equal (addr+1) mod DEPTH, including addr_next=0 when addr=DEPTH-1.
REQ-016 inc is level-sensitive per cycle; no handshake, stall or back-pressure exists, and inc is never ignored outside reset.
REQ-017 For ADDR_WIDTH=1, addr SHALL alternate 0,1,0 with wrap pulsing on every second increment.

Reset
REQ-018 rst high at a rising edge SHALL set addr=0, wrap=0 and phase=0, overriding inc.
REQ-019 Reset mid-sequence SHALL discard all progress; the first inc after rst deasserts moves addr from 0 to 1.
REQ-020 Power-up register initial values SHALL equal the reset values (addr=0, wrap=0, phase=0).
REQ-021 While rst is high, addr_next SHALL read 1 after the first reset edge.

Configuration
REQ-022 Macro FIFO_ADDR_GEN_PHASE_EN, when defined, SHALL implement phase as a register that resets to 0 and toggles on every edge where inc is high and addr is DEPTH-1.
REQ-023 Without FIFO_ADDR_GEN_PHASE_EN, the phase port SHALL remain present, tied constant 0, with no phase register; all other behaviour is identical.
REQ-024 A parent FIFO SHALL be able to use {phase,addr} pairs from a read and a write generator to detect full and empty only when the macro is defined.

Verification
REQ-025 ADDR_WIDTH=4, rst for 2 cycles, then inc=1 for 16 cycles -> addr 1..15 then 0; wrap=1 only in the cycle after 15->0; phase 0->1.
REQ-026 ADDR_WIDTH=4, alternate inc=1/0 for 10 cycles -> addr steps 0,1,1,2,2,3,3,4,4,5; addr_next always addr+1.
REQ-027 Drive addr to 9, then assert rst with inc=1 -> addr=0, wrap=0, phase=0 next cycle; after rst drops, one inc -> addr=1.
REQ-028 ADDR_WIDTH=2, inc held high for 12 cycles -> addr 1,2,3,0 repeating; wrap pulses 3 times; phase toggles 3 times (macro defined) or stays 0 (macro undefined).
REQ-029 addr=15, inc=0 for 5 cycles -> addr stays 15, addr_next=0, wrap=0, phase unchanged.
REQ-030 A randomized inc stream against a reference counter -> addr, wrap and phase match every cycle, and addr never exceeds DEPTH-1.
